// File: rtl/imuldiv_muldiv_dispatch.sv
// Muldiv front-end: routes core requests to the iterative multiplier or divider
// and returns results strictly in request order using a small tag FIFO.
module imuldiv_muldiv_dispatch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [31:0] muldivreq_msg_a,
  input  logic [31:0] muldivreq_msg_b,
  input  logic        muldivreq_val,
  output logic        muldivreq_rdy,

  output logic [31:0] muldivresp_msg_result,
  output logic        muldivresp_val,
  input  logic        muldivresp_rdy,

  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic        mulreq_val,
  input  logic        mulreq_rdy,

  input  logic [63:0] mulresp_msg_result,
  input  logic        mulresp_val,
  output logic        mulresp_rdy,

  output logic        divreq_msg_fn,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,

  input  logic [63:0] divresp_msg_result,
  input  logic        divresp_val,
  output logic        divresp_rdy
);

  // Handshake rule for every port pair: a transfer happens on the posedge
  // where val and rdy are both high; val never depends on the opposite rdy.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    KIND_MUL_LO = 2'd0,
    KIND_DIV_Q  = 2'd1,
    KIND_DIV_R  = 2'd2,
    KIND_ZERO   = 2'd3
  } kind_e;

  kind_e          tag_mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  kind_e          req_kind;
  kind_e          head_kind;
  logic           req_is_mul;
  logic           req_is_div;
  logic           req_unsigned;
  logic [31:0]    unused_mul_hi;

  assign full          = (count == FULL_COUNT);
  assign empty         = (count == '0);
  assign head_kind     = tag_mem[rd_ptr];
  assign unused_mul_hi = mulresp_msg_result[63:32];

  always_comb begin
    req_kind     = KIND_ZERO;
    req_is_mul   = 1'b0;
    req_is_div   = 1'b0;
    req_unsigned = 1'b0;
    case (muldivreq_msg_fn)
      3'd0: begin req_kind = KIND_MUL_LO; req_is_mul = 1'b1; end
      3'd1: begin req_kind = KIND_DIV_Q;  req_is_div = 1'b1; end
      3'd2: begin req_kind = KIND_DIV_Q;  req_is_div = 1'b1; req_unsigned = 1'b1; end
      3'd3: begin req_kind = KIND_DIV_R;  req_is_div = 1'b1; end
      3'd4: begin req_kind = KIND_DIV_R;  req_is_div = 1'b1; req_unsigned = 1'b1; end
      default: req_kind = KIND_ZERO;
    endcase
  end

  assign mulreq_msg_a  = muldivreq_msg_a;
  assign mulreq_msg_b  = muldivreq_msg_b;
  assign divreq_msg_a  = muldivreq_msg_a;
  assign divreq_msg_b  = muldivreq_msg_b;
  assign divreq_msg_fn = req_unsigned;
  assign mulreq_val    = muldivreq_val & req_is_mul & ~full;
  assign divreq_val    = muldivreq_val & req_is_div & ~full;

  // Full blocks acceptance even if the head pops this cycle.
  assign muldivreq_rdy = ~full & (req_is_mul ? mulreq_rdy :
                                  req_is_div ? divreq_rdy : 1'b1);

  always_comb begin
    muldivresp_val        = 1'b0;
    muldivresp_msg_result = 32'h0;
    mulresp_rdy           = 1'b0;
    divresp_rdy           = 1'b0;
    if (!empty) begin
      case (head_kind)
        KIND_MUL_LO: begin
          muldivresp_val        = mulresp_val;
          muldivresp_msg_result = mulresp_msg_result[31:0];
          mulresp_rdy           = muldivresp_rdy;
        end
        KIND_DIV_Q: begin
          muldivresp_val        = divresp_val;
          muldivresp_msg_result = divresp_msg_result[31:0];
          divresp_rdy           = muldivresp_rdy;
        end
        KIND_DIV_R: begin
          muldivresp_val        = divresp_val;
          muldivresp_msg_result = divresp_msg_result[63:32];
          divresp_rdy           = muldivresp_rdy;
        end
        default: begin
          muldivresp_val        = 1'b1;
          muldivresp_msg_result = 32'h0;
        end
      endcase
    end
  end

  assign push = muldivreq_val & muldivreq_rdy;
  assign pop  = muldivresp_val & muldivresp_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) tag_mem[i] <= KIND_ZERO;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= req_kind;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// Bench for imuldiv_muldiv_dispatch: mock multiplier/divider units, an arithmetic
// reference model feeding an expected-result queue, and directed plus random scenarios.
module tb_imuldiv_muldiv_dispatch;

  logic        clk;
  logic        reset;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
  logic        muldivreq_val, muldivreq_rdy;
  logic [31:0] muldivresp_msg_result;
  logic        muldivresp_val, muldivresp_rdy;
  logic [31:0] mulreq_msg_a, mulreq_msg_b;
  logic        mulreq_val, mulreq_rdy;
  logic [63:0] mulresp_msg_result;
  logic        mulresp_val, mulresp_rdy;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a, divreq_msg_b;
  logic        divreq_val, divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val, divresp_rdy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [63:0] mul_q[$];
  logic [63:0] div_q[$];

  bit rand_mode   = 0;
  bit mul_rdy_en  = 1;
  bit div_rdy_en  = 1;
  bit mul_resp_en = 1;
  bit div_resp_en = 1;

  imuldiv_muldiv_dispatch #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val),
    .muldivreq_rdy(muldivreq_rdy),
    .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
    .muldivresp_rdy(muldivresp_rdy),
    .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b),
    .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
    .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
    .mulresp_rdy(mulresp_rdy),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a),
    .divreq_msg_b(divreq_msg_b), .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
    .divresp_rdy(divresp_rdy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] fn,
                                             input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    case (fn)
      3'd0: r = a * b;
      3'd1: r = sa / sb;
      3'd2: r = a / b;
      3'd3: r = sa % sb;
      3'd4: r = a % b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // ---------------- mock units: drive at posedge+1 ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mulreq_rdy  = rand_mode ? ($urandom_range(0, 3) != 0) : mul_rdy_en;
      divreq_rdy  = rand_mode ? ($urandom_range(0, 3) != 0) : div_rdy_en;
      mulresp_val = mul_resp_en && (mul_q.size() > 0) &&
                    (!rand_mode || ($urandom_range(0, 2) != 0));
      divresp_val = div_resp_en && (div_q.size() > 0) &&
                    (!rand_mode || ($urandom_range(0, 4) == 0));
      mulresp_msg_result = (mul_q.size() > 0) ? mul_q[0] : 64'h0;
      divresp_msg_result = (div_q.size() > 0) ? div_q[0] : 64'h0;
      if (rand_mode) muldivresp_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard: sample at negedge ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (mulresp_val && mulresp_rdy) void'(mul_q.pop_front());
      if (divresp_val && divresp_rdy) void'(div_q.pop_front());
      if (mulreq_val && mulreq_rdy)
        mul_q.push_back({32'h0, mulreq_msg_a} * {32'h0, mulreq_msg_b});
      if (divreq_val && divreq_rdy) begin
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = divreq_msg_a;
        sb = divreq_msg_b;
        if (divreq_msg_fn) begin q = divreq_msg_a / divreq_msg_b; r = divreq_msg_a % divreq_msg_b; end
        else begin q = sa / sb; r = sa % sb; end
        div_q.push_back({r, q});
      end
      if (muldivresp_val && muldivresp_rdy) begin
        checks++;
        got_q.push_back(muldivresp_msg_result);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got response %h, expected none", muldivresp_msg_result);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (muldivresp_msg_result !== e) begin
            errors++;
            $display("FAIL sb_result: got %h, expected %h", muldivresp_msg_result, e);
          end
        end
      end
      if (muldivreq_val && muldivreq_rdy)
        exp_q.push_back(ref_result(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b));
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send_req(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    muldivreq_msg_fn = fn;
    muldivreq_msg_a  = a;
    muldivreq_msg_b  = b;
    muldivreq_val    = 1'b1;
    @(negedge clk);
    while (!muldivreq_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!muldivreq_rdy) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: fn=%0d not accepted, got rdy=%b expected 1", fn, muldivreq_rdy);
    end
    @(posedge clk);
    #1;
    muldivreq_val = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    if (!rand_mode) muldivresp_rdy = 1'b1;
    @(negedge clk);
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (muldivresp_val !== 1'b0 || mulresp_rdy !== 1'b0 || divresp_rdy !== 1'b0 ||
        muldivresp_msg_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got val=%b mrdy=%b drdy=%b res=%h, expected 0/0/0/0",
               muldivresp_val, mulresp_rdy, divresp_rdy, muldivresp_msg_result);
    end
    checks++;
    if (muldivreq_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_rdy: got %b expected 1", muldivreq_rdy);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul();
    got_q.delete();
    muldivresp_rdy   = 1'b1;
    muldivreq_msg_fn = 3'd0;
    muldivreq_msg_a  = 32'd7;
    muldivreq_msg_b  = 32'd6;
    muldivreq_val    = 1'b1;
    @(negedge clk);
    checks++;
    if (mulreq_val !== 1'b1 || divreq_val !== 1'b0 || mulreq_msg_a !== 32'd7 ||
        mulreq_msg_b !== 32'd6) begin
      errors++;
      $display("FAIL mul_forward: got mval=%b dval=%b a=%0d b=%0d, expected 1/0/7/6",
               mulreq_val, divreq_val, mulreq_msg_a, mulreq_msg_b);
    end
    @(posedge clk);
    #1;
    muldivreq_val = 1'b0;
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'd42) begin
      errors++;
      $display("FAIL mul_result: got count=%0d first=%0d, expected 1 response of 42",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
  endtask

  task automatic test_div();
    got_q.delete();
    muldivreq_msg_fn = 3'd1;
    muldivreq_msg_a  = 32'hFFFF_FFF9;
    muldivreq_msg_b  = 32'd2;
    muldivreq_val    = 1'b1;
    @(negedge clk);
    checks++;
    if (divreq_val !== 1'b1 || mulreq_val !== 1'b0 || divreq_msg_fn !== 1'b0) begin
      errors++;
      $display("FAIL div_forward: got dval=%b mval=%b fn=%b, expected 1/0/0",
               divreq_val, mulreq_val, divreq_msg_fn);
    end
    @(posedge clk);
    #1;
    muldivreq_msg_fn = 3'd4;
    muldivreq_msg_a  = 32'd7;
    muldivreq_msg_b  = 32'd2;
    @(negedge clk);
    checks++;
    if (divreq_val !== 1'b1 || divreq_msg_fn !== 1'b1) begin
      errors++;
      $display("FAIL remu_forward: got dval=%b fn=%b, expected 1/1", divreq_val, divreq_msg_fn);
    end
    @(posedge clk);
    #1;
    muldivreq_val = 1'b0;
    drain();
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 32'hFFFF_FFFD || got_q[1] !== 32'h1) begin
      errors++;
      $display("FAIL div_results: got count=%0d, expected FFFFFFFD then 00000001", got_q.size());
    end
  endtask

  task automatic test_out_of_order();
    got_q.delete();
    muldivresp_rdy = 1'b1;
    div_resp_en    = 1'b0;
    send_req(3'd1, 32'd100, 32'd7);
    send_req(3'd0, 32'd5, 32'd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mulresp_val !== 1'b1 || mulresp_rdy !== 1'b0 || muldivresp_val !== 1'b0) begin
      errors++;
      $display("FAIL ooo_hold: got mval=%b mrdy=%b rval=%b, expected 1/0/0",
               mulresp_val, mulresp_rdy, muldivresp_val);
    end
    @(posedge clk);
    #1;
    div_resp_en = 1'b1;
    drain();
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 32'd14 || got_q[1] !== 32'd25) begin
      errors++;
      $display("FAIL ooo_order: got count=%0d, expected 14 then 25", got_q.size());
    end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    muldivresp_rdy   = 1'b0;
    muldivreq_msg_fn = 3'd5;
    muldivreq_msg_a  = $urandom;
    muldivreq_msg_b  = $urandom;
    muldivreq_val    = 1'b1;
    @(negedge clk);
    checks++;
    if (muldivreq_rdy !== 1'b1 || muldivresp_val !== 1'b0) begin
      errors++;
      $display("FAIL zero_accept: got rdy=%b rval=%b, expected 1/0", muldivreq_rdy, muldivresp_val);
    end
    @(posedge clk);
    #1;
    muldivreq_val = 1'b0;
    @(negedge clk);
    checks++;
    if (muldivresp_val !== 1'b1 || muldivresp_msg_result !== 32'h0) begin
      errors++;
      $display("FAIL zero_latency: got val=%b res=%h, expected 1/0", muldivresp_val, muldivresp_msg_result);
    end
    @(posedge clk);
    #1;
    send_req(3'd6, $urandom, $urandom);
    send_req(3'd7, $urandom, $urandom);
    send_req(3'd5, $urandom, $urandom);
    muldivreq_msg_fn = 3'd6;
    muldivreq_val    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (muldivreq_rdy !== 1'b0 || mulreq_val !== 1'b0 || divreq_val !== 1'b0) begin
        errors++;
        $display("FAIL full_block: got rdy=%b mval=%b dval=%b, expected 0/0/0",
                 muldivreq_rdy, mulreq_val, divreq_val);
      end
    end
    @(posedge clk);
    #1;
    muldivresp_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (muldivreq_rdy !== 1'b0 || muldivresp_val !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_bypass: got rdy=%b rval=%b, expected 0/1", muldivreq_rdy, muldivresp_val);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (muldivreq_rdy !== 1'b1) begin
      errors++;
      $display("FAIL after_pop_accept: got rdy=%b expected 1", muldivreq_rdy);
    end
    @(posedge clk);
    #1;
    muldivreq_val = 1'b0;
    drain();
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("FAIL zero_count: got %0d responses, expected 5", got_q.size());
    end
  endtask

  task automatic test_async_reset();
    got_q.delete();
    muldivresp_rdy = 1'b0;
    mul_resp_en    = 1'b0;
    for (int i = 1; i <= 3; i++) send_req(3'd0, i, 32'd2);
    muldivreq_msg_fn = 3'd0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (muldivresp_val !== 1'b0 || mulresp_rdy !== 1'b0 || divresp_rdy !== 1'b0 ||
        muldivresp_msg_result !== 32'h0 || muldivreq_rdy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got rval=%b mrdy=%b drdy=%b res=%h qrdy=%b, expected 0/0/0/0/1",
               muldivresp_val, mulresp_rdy, divresp_rdy, muldivresp_msg_result, muldivreq_rdy);
    end
    exp_q.delete();
    mul_q.delete();
    div_q.delete();
    @(posedge clk);
    #1;
    reset       = 1'b1;
    mul_resp_en = 1'b1;
    @(posedge clk);
    #1;
    send_req(3'd0, 32'd3, 32'd3);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'd9) begin
      errors++;
      $display("FAIL post_reset_mul: got count=%0d, expected one response of 9", got_q.size());
    end
  endtask

  task automatic test_random();
    logic [2:0]  fn;
    logic [31:0] a, b;
    rand_mode = 1;
    for (int i = 0; i < 120; i++) begin
      fn = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (($urandom_range(0, 3)) == 0) b = 32'($urandom_range(1, 9));
      if (b == 32'h0) b = 32'd1;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      send_req(fn, a, b);
    end
    drain();
    rand_mode      = 0;
    muldivresp_rdy = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset            = 1'b0;
    muldivreq_msg_fn = 3'd0;
    muldivreq_msg_a  = 32'h0;
    muldivreq_msg_b  = 32'h0;
    muldivreq_val    = 1'b0;
    muldivresp_rdy   = 1'b0;
    mulreq_rdy       = 1'b1;
    divreq_rdy       = 1'b1;
    mulresp_val      = 1'b0;
    divresp_val      = 1'b0;
    mulresp_msg_result = 64'h0;
    divresp_msg_result = 64'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_mul();
    test_div();
    test_out_of_order();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imuldiv_muldiv_dispatch.md
# imuldiv_muldiv_dispatch

Front-end of the integer multiply/divide subsystem: accepts 3-bit-function muldiv requests from the core, forwards each to the iterative multiplier or the iterative divider, and returns one 32-bit result per request, in request order. It sits directly upstream of the iterative divider (divreq/divresp) and multiplier (mulreq/mulresp), and tracks up to DEPTH in-flight operations in a tag FIFO.

## Interface
- DEPTH, 4: max in-flight requests; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- muldivreq_msg_fn  in  3  0=MUL, 1=DIV, 2=DIVU, 3=REM, 4=REMU, 5–7 illegal
- muldivreq_msg_a / muldivreq_msg_b  in  32 each  operands
- muldivreq_val  in  1 / muldivreq_rdy  out  1  request handshake
- muldivresp_msg_result  out  32  result
- muldivresp_val  out  1 / muldivresp_rdy  in  1  response handshake
- mulreq_msg_a / mulreq_msg_b  out  32 each; mulreq_val  out  1; mulreq_rdy  in  1
- mulresp_msg_result  in  64; mulresp_val  in  1; mulresp_rdy  out  1
- divreq_msg_fn  out  1  0=signed, 1=unsigned; divreq_msg_a / divreq_msg_b  out  32 each; divreq_val  out  1; divreq_rdy  in  1
- divresp_msg_result  in  64  {remainder[63:32], quotient[31:0]}; divresp_val  in  1; divresp_rdy  out  1

## Operation
- Tag FIFO: DEPTH entries of 2-bit kind: MUL_LO, DIV_Q, DIV_R, ZERO; write ptr, read ptr, count 0..DEPTH.
- Decode: MUL→MUL_LO to mul unit; DIV/DIVU→DIV_Q; REM/REMU→DIV_R; DIV/REM→divreq_msg_fn=0, DIVU/REMU→1; fn 5–7→ZERO, touches no unit.
- Operands pass through unchanged to both units; unit val only asserted for the selected unit.
- mulreq_val = muldivreq_val & fn==MUL & !full; divreq_val = muldivreq_val & fn∈{1..4} & !full.
- muldivreq_rdy = !full & (MUL: mulreq_rdy; DIV class: divreq_rdy; ZERO: 1).
- Push tag when muldivreq_val & muldivreq_rdy.
- Response side keyed by head tag only (when !empty):
  - MUL_LO: val=mulresp_val, result=mulresp_msg_result[31:0], mulresp_rdy=muldivresp_rdy.
  - DIV_Q: val=divresp_val, result=divresp_msg_result[31:0], divresp_rdy=muldivresp_rdy.
  - DIV_R: as DIV_Q but result=divresp_msg_result[63:32].
  - ZERO: val=1, result=32'h0.
- Unit not matching head: its resp_rdy=0; its response waits (guarantees in-order return when units finish out of order).
- Pop head when muldivresp_val & muldivresp_rdy.

## Timing
- Reset (reset=0, async): count=0, ptrs=0; hence muldivresp_val=0, mulresp_rdy=0, divresp_rdy=0, result=32'h0 while empty; muldivreq_rdy follows unit rdy (count 0 ≠ full).
- Reset asserted mid-operation: all tags dropped; unit responses arriving after reset are not consumed (resp_rdy=0) until a matching tag is at head — system reset must reset units too.
- Request forwarding: zero-cycle combinational; tag written on the accepting posedge.
- Response: combinational from unit resp to muldivresp in the cycle the tag is at head; ZERO earliest response one cycle after acceptance.
- Empty: muldivresp_val=0, all unit resp_rdy=0; result=32'h0.
- Full (count==DEPTH): muldivreq_rdy=0, unit req vals 0, even if a pop occurs same cycle (no full bypass).
- Simultaneous push and pop (not full): count unchanged, both ptrs advance; pointers wrap modulo DEPTH.
- Push into empty with same-cycle unit response: not returned that cycle (tag not yet at head).
- Result width: 32 bits; mul upper 32 bits discarded.

## Test plan
- MUL a=7,b=6 → mulreq_val same cycle; unit returns 64'd42 → muldivresp_msg_result=32'd42, one response, FIFO empty after.
- DIV a=-7 (32'hFFFFFFF9),b=2 → divreq_msg_fn=0; divider returns {32'hFFFFFFFF,32'hFFFFFFFD}; then REMU 7,2 → divreq_msg_fn=1 → results 32'hFFFFFFFD then 32'h1.
- Out-of-order: DIV issued, then MUL; mock mul responds first → mulresp_rdy held 0 until DIV result returned; order DIV, MUL.
- Backpressure: issue 5 ZERO requests with muldivresp_rdy=0 → 4 accepted, 5th sees muldivreq_rdy=0; release rdy → four 32'h0 responses, then 5th accepted.
- Full + pop same cycle: FIFO full, muldivresp_rdy=1, new request → not accepted that cycle, accepted next.
- Async reset with 3 in flight → outputs 0/empty immediately without clock edge; new MUL 3×3 after reset → 32'd9.
